// File: rtl/bcd_to_bin_serial_if.sv
// rtl/bcd_to_bin_serial_if.sv - input/output handshake bundle for the serial BCD-to-binary decoder
// slave is the decoder side; master is the producer/consumer side.
interface bcd_to_bin_serial_if #(
    parameter int NDIGITS = 3,
    parameter int BIN_W   = 10
);
    logic                   in_valid;
    logic                   in_ready;
    logic [4*NDIGITS-1:0]   bcd_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [BIN_W-1:0]       bin_out;
    logic                   err;

    modport slave (
        input  in_valid, bcd_in, out_ready,
        output in_ready, out_valid, bin_out, err
    );

    modport master (
        output in_valid, bcd_in, out_ready,
        input  in_ready, out_valid, bin_out, err
    );
endinterface

// File: rtl/bcd_to_bin_serial.sv
// rtl/bcd_to_bin_serial.sv - iterative reverse double-dabble BCD-to-binary decoder
// One shift per clock; malformed digits short-circuit straight to the result state.
module bcd_to_bin_serial #(
    parameter int NDIGITS = 3,
    parameter int BIN_W   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_to_bin_serial_if.slave   bus
);
    localparam int BCD_W = 4 * NDIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               bad_digit;
    logic [BCD_W-1:0]   bcd_shifted;
    logic [BCD_W-1:0]   bcd_fixed;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // A digit whose MSB is set after halving borrowed 10/2 from its neighbour; -3 restores base 10.
    always_comb begin
        bcd_shifted = bcd_q >> 1;
        bcd_fixed   = bcd_shifted;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bcd_shifted[4*i+3]) begin
                bcd_fixed[4*i +: 4] = bcd_shifted[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    bcd_d   = bus.bcd_in;
                    bin_d   = '0;
                    cnt_d   = '0;
                    err_d   = bad_digit;
                    state_d = bad_digit ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = bcd_fixed;
                bin_d = {bcd_q[0], bin_q[BIN_W-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.bin_out   = bin_q;
    assign bus.err       = err_q;
endmodule
